frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
Controller that sequences one image frame through the windowing/convolution pipeline.
- Arms on a start command, then admits exactly one frame of input pixels, gating the source with the output FIFO's prog_full backpressure.
- Counts convolved pixels leaving the output FIFO and raises a frame-done interrupt when the full frame has drained.
- Detects protocol errors: start while busy, and a drain that stops producing output.

Parameters:
IMG_W, 512, pixels per line
IMG_H, 512, lines per frame
DRAIN_TIMEOUT, 4096, idle cycles allowed in DRAIN with no output handshake before error
CNT_W, $clog2(IMG_W*IMG_H+1), width of pixel counters

Ports:
in_clk  input  1  clock
in_rst  input  1  synchronous active-high reset
in_start  input  1  single-cycle frame start command
in_abort  input  1  abort current frame
in_data_valid  input  1  source pixel valid
in_data  input  8  source pixel
out_data_ready  output  1  ready to source
in_prog_full  input  1  output FIFO prog_full
out_pixel_data  output  8  pixel to windowing block
out_pixel_data_valid  output  1  pixel valid to windowing block
in_m_valid  input  1  output FIFO tvalid (monitored)
in_m_ready  input  1  sink tready (monitored)
out_busy  output  1  frame in progress
out_intr  output  1  frame-done pulse
out_err_start  output  1  sticky: start received while busy
out_err_timeout  output  1  sticky: drain timeout
out_in_count  output  CNT_W  pixels accepted this frame
out_out_count  output  CNT_W  output pixels consumed this frame

Behaviour:
- Constants: IN_TOTAL = IMG_W*IMG_H; OUT_TOTAL = IMG_W*(IMG_H-2), the 3x3 window losing two lines.
- Reset values: every output is 0 and the state is IDLE. Reset mid-frame returns to IDLE in the same cycle and clears all counters and flags.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - out_data_ready=0, out_busy=0.
  - in_start moves to FEED and, in the same edge, clears both counters and both sticky errors.
- FEED:
  - out_busy=1. out_data_ready = !in_prog_full, combinational.
  - Accept when in_data_valid && out_data_ready. The accepted pixel appears on out_pixel_data with out_pixel_data_valid=1 on the next cycle (1-cycle registered latency). Otherwise out_pixel_data_valid=0 and data holds.
  - in_count increments on each accept.
  - The accept that makes in_count == IN_TOTAL moves to DRAIN. out_data_ready is 0 from that next cycle.
- DRAIN:
  - out_data_ready=0.
  - An idle counter resets on every output handshake and increments otherwise.
  - Reaching DRAIN_TIMEOUT sets out_err_timeout and moves to DONE.
- Output counting (FEED and DRAIN): out_count increments on in_m_valid && in_m_ready, saturating at OUT_TOTAL. When out_count reaches OUT_TOTAL in DRAIN, move to DONE. If it reaches OUT_TOTAL in FEED, DONE is taken on entry to DRAIN.
- DONE:
  - out_intr=1 for exactly one cycle, then IDLE. Counters hold until the next start.
- in_start outside IDLE is ignored and sets out_err_start. in_start in the DONE cycle is also treated as an error.
- in_abort in FEED or DRAIN: go to IDLE next edge, no out_intr, counters hold. If in_abort and in_start arrive together in IDLE, in_start wins.
- A valid pixel present while in_prog_full is high is not accepted; data must be held by the source per valid/ready rules.
- Counters never wrap: in_count stops at IN_TOTAL because accepts are blocked after it.

Decomposition:
- Shared package `img_pkg` holds:
  - the state enum (IDLE, FEED, DRAIN, DONE);
  - IN_TOTAL and OUT_TOTAL as functions of IMG_W and IMG_H;
  - CNT_W derivation and the pixel width constant of 8.
- One natural sub-module, `pixel_counter`: a clear/enable/saturate counter of parameterized width and limit, instanced for in_count, out_count and the drain idle timer.

Test Plan:
All scenarios use IMG_W=8, IMG_H=4, so IN_TOTAL=32 and OUT_TOTAL=16; DRAIN_TIMEOUT=20.
- Nominal frame: start, 32 back-to-back valid pixels, sink always ready, 16 output handshakes → in_count=32, out_count=16, single out_intr pulse, out_busy low afterwards, out_pixel_data sequence equals input delayed 1 cycle.
- Backpressure: hold in_prog_full=1 for 5 cycles mid-frame → out_data_ready=0 and no accepts in those cycles; final in_count still exactly 32.
- Over-length source: source offers 40 pixels → exactly 32 accepted, out_data_ready=0 from the cycle after the 32nd accept.
- Start while busy: start pulse in FEED → out_err_start=1, frame unaffected; the next start in IDLE clears it.
- Drain timeout: only 10 output handshakes → out_err_timeout set 20 cycles after the last handshake, out_intr pulses, out_count=10.
- Abort and reset: in_abort at in_count=12 → IDLE, no out_intr, in_count=12. in_rst asserted in DRAIN → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and frame-geometry helpers for the image pipeline controller.
// Frame totals are functions so each instance can derive them from its own geometry.
package img_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int in_total(input int w, input int h);
    return w * h;
  endfunction

  // A 3x3 window loses one line at the top and one at the bottom.
  function automatic int out_total(input int w, input int h);
    return w * (h - 2);
  endfunction

  function automatic int cnt_width(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/pixel_counter.sv
// Up-counter with synchronous clear and enable that saturates at LIMIT.
// Clear has priority over enable.
module pixel_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIMIT_V)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/frame_sequencer.sv
// Sequences one frame through the convolution pipeline: admits IN_TOTAL pixels,
// counts OUT_TOTAL drained outputs, flags start-while-busy and drain stalls.
module frame_sequencer
  import img_pkg::*;
#(
  parameter int IMG_W         = 512,
  parameter int IMG_H         = 512,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int CNT_W         = cnt_width(IMG_W, IMG_H)
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic             in_abort,
  input  logic             in_data_valid,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_data_ready,
  input  logic             in_prog_full,
  output logic [PIX_W-1:0] out_pixel_data,
  output logic             out_pixel_data_valid,
  input  logic             in_m_valid,
  input  logic             in_m_ready,
  output logic             out_busy,
  output logic             out_intr,
  output logic             out_err_start,
  output logic             out_err_timeout,
  output logic [CNT_W-1:0] out_in_count,
  output logic [CNT_W-1:0] out_out_count
);

  localparam int IN_TOTAL  = in_total(IMG_W, IMG_H);
  localparam int OUT_TOTAL = out_total(IMG_W, IMG_H);
  localparam int IDLE_W    = $clog2(DRAIN_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             pix_valid_q, pix_valid_d;
  logic             err_start_q, err_start_d;
  logic             err_to_q, err_to_d;

  logic             frame_clr;
  logic             accept;
  logic             last_accept;
  logic             m_hs;
  logic             out_hs;
  logic             out_full;
  logic             in_full;
  logic             idle_clr;
  logic             timeout_hit;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  // in_full is redundant with the FEED->DRAIN move but guarantees in_count can never wrap.
  assign in_full        = (in_cnt == CNT_W'(IN_TOTAL));
  assign out_data_ready = (state_q == FEED) && !in_prog_full && !in_full;
  assign accept         = in_data_valid && out_data_ready;
  assign last_accept    = accept && (in_cnt == CNT_W'(IN_TOTAL - 1));
  assign m_hs           = in_m_valid && in_m_ready;
  assign out_hs         = m_hs && ((state_q == FEED) || (state_q == DRAIN));
  assign out_full       = (out_cnt == CNT_W'(OUT_TOTAL));
  assign idle_clr       = (state_q != DRAIN) || m_hs;
  assign timeout_hit    = !m_hs && (idle_cnt == IDLE_W'(DRAIN_TIMEOUT - 1));

  pixel_counter #(.WIDTH(CNT_W), .LIMIT(IN_TOTAL)) u_in_count (
    .clk_i  (in_clk),
    .rst_i  (in_rst),
    .clr_i  (frame_clr),
    .en_i   (accept),
    .count_o(in_cnt)
  );

  pixel_counter #(.WIDTH(CNT_W), .LIMIT(OUT_TOTAL)) u_out_count (
    .clk_i  (in_clk),
    .rst_i  (in_rst),
    .clr_i  (frame_clr),
    .en_i   (out_hs),
    .count_o(out_cnt)
  );

  // Counts consecutive DRAIN cycles without an output handshake.
  pixel_counter #(.WIDTH(IDLE_W), .LIMIT(DRAIN_TIMEOUT)) u_idle_timer (
    .clk_i  (in_clk),
    .rst_i  (in_rst),
    .clr_i  (idle_clr),
    .en_i   (1'b1),
    .count_o(idle_cnt)
  );

  always_comb begin
    state_d     = state_q;
    err_start_d = err_start_q;
    err_to_d    = err_to_q;
    frame_clr   = 1'b0;
    out_busy    = 1'b1;
    out_intr    = 1'b0;
    pix_valid_d = accept;
    pix_d       = accept ? in_data : pix_q;

    unique case (state_q)
      IDLE: begin
        out_busy = 1'b0;
        if (in_start) begin
          state_d     = FEED;
          frame_clr   = 1'b1;
          err_start_d = 1'b0;
          err_to_d    = 1'b0;
        end
      end
      FEED: begin
        if (in_abort) begin
          state_d = IDLE;
        end else if (last_accept) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (in_abort) begin
          state_d = IDLE;
        end else if (out_full) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d  = DONE;
          err_to_d = 1'b1;
        end
      end
      DONE: begin
        out_intr = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (in_start && (state_q != IDLE)) begin
      err_start_d = 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      err_start_q <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
      err_start_q <= err_start_d;
      err_to_q    <= err_to_d;
    end
  end

  assign out_pixel_data       = pix_q;
  assign out_pixel_data_valid = pix_valid_q;
  assign out_err_start        = err_start_q;
  assign out_err_timeout      = err_to_q;
  assign out_in_count         = in_cnt;
  assign out_out_count        = out_cnt;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized frame scenarios for frame_sequencer against a frame-level reference model.
// Geometry 8x4 with a 20-cycle drain timeout: 32 pixels in, 16 expected out.
module tb_frame_sequencer;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int TO    = 20;
  localparam int IN_T  = W * H;
  localparam int OUT_T = W * (H - 2);
  localparam int CW    = $clog2(W * H + 1);
  localparam int BOUND = 400;

  logic          in_clk = 1'b0;
  logic          in_rst, in_start, in_abort, in_data_valid, in_prog_full;
  logic          in_m_valid, in_m_ready;
  logic [7:0]    in_data;
  logic          out_data_ready, out_pixel_data_valid, out_busy, out_intr;
  logic          out_err_start, out_err_timeout;
  logic [7:0]    out_pixel_data;
  logic [CW-1:0] out_in_count, out_out_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_pix = 8'h00;

  frame_sequencer #(.IMG_W(W), .IMG_H(H), .DRAIN_TIMEOUT(TO)) dut (
    .in_clk              (in_clk),
    .in_rst              (in_rst),
    .in_start            (in_start),
    .in_abort            (in_abort),
    .in_data_valid       (in_data_valid),
    .in_data             (in_data),
    .out_data_ready      (out_data_ready),
    .in_prog_full        (in_prog_full),
    .out_pixel_data      (out_pixel_data),
    .out_pixel_data_valid(out_pixel_data_valid),
    .in_m_valid          (in_m_valid),
    .in_m_ready          (in_m_ready),
    .out_busy            (out_busy),
    .out_intr            (out_intr),
    .out_err_start       (out_err_start),
    .out_err_timeout     (out_err_timeout),
    .out_in_count        (out_in_count),
    .out_out_count       (out_out_count)
  );

  always #5 in_clk = ~in_clk;

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_start = 0; in_abort = 0; in_data_valid = 0; in_data = 8'h00;
    in_prog_full = 0; in_m_valid = 0; in_m_ready = 0;
  endtask

  // Runs one frame from a start pulse. Phases of the model: 0 out, 1 feed, 2 drain, 3 done.
  task automatic drive_frame(input int offer_n, input int bp_at, input int bp_len, input bit rnd,
                             input int hs_from, input int hs_max, input int start_at,
                             input int abort_acc, input bit stop_drain,
                             output int accepted, output int hs_cnt, output int intr_seen,
                             output int to_gap);
    logic [7:0] pix[$];
    int  phase, idx, idle, cyc, last_hs, exp_out;
    bit  v, pf, hs, acc, ab, exp_ready, exp_to, exp_err_start;
    for (int i = 0; i < offer_n; i++) pix.push_back(8'($urandom));
    accepted = 0; hs_cnt = 0; intr_seen = 0; to_gap = -1;
    phase = 1; idx = 0; idle = 0; cyc = 0; last_hs = 0; exp_err_start = 0;
    in_start = 1;
    tick();
    in_start = 0;
    while (phase != 0 && cyc < BOUND) begin
      ab = (phase == 1) && (accepted == abort_acc);
      v  = (idx < offer_n) && !ab && (!rnd || $urandom_range(0, 3) != 0);
      in_data_valid = v;
      if (v) in_data = pix[idx];
      else   in_data = 8'($urandom);
      pf = rnd ? ($urandom_range(0, 3) == 0) : (cyc >= bp_at && cyc < bp_at + bp_len);
      in_prog_full = pf;
      hs = (phase == 1 || phase == 2) && cyc >= hs_from && hs_cnt < hs_max &&
           (!rnd || $urandom_range(0, 1) == 1);
      if (hs) begin
        in_m_valid = 1; in_m_ready = 1;
      end else begin
        case ($urandom_range(0, 2))
          0: begin in_m_valid = 1; in_m_ready = 0; end
          1: begin in_m_valid = 0; in_m_ready = 1; end
          default: begin in_m_valid = 0; in_m_ready = 0; end
        endcase
      end
      in_start = (cyc == start_at);
      in_abort = ab;
      #1;
      exp_ready = (phase == 1) && !pf;
      checks++;
      if (out_data_ready !== exp_ready)
        begin errors++; $display("FAIL ready cyc=%0d got %b want %b", cyc, out_data_ready, exp_ready); end
      acc = v && exp_ready;
      tick();
      cyc++;
      if (in_start) exp_err_start = 1;
      if (acc) begin model_pix = pix[idx]; idx++; accepted++; end
      if (hs) begin hs_cnt++; last_hs = cyc; end
      exp_out = (hs_cnt > OUT_T) ? OUT_T : hs_cnt;
      checks++;
      if (out_pixel_data_valid !== acc || out_pixel_data !== model_pix)
        begin errors++; $display("FAIL pixel cyc=%0d got v=%b d=%h want v=%b d=%h", cyc,
                                 out_pixel_data_valid, out_pixel_data, acc, model_pix); end
      checks++;
      if (out_in_count !== CW'(accepted) || out_out_count !== CW'(exp_out))
        begin errors++; $display("FAIL counts cyc=%0d got in=%0d out=%0d want in=%0d out=%0d", cyc,
                                 out_in_count, out_out_count, accepted, exp_out); end
      checks++;
      if (out_err_start !== exp_err_start)
        begin errors++; $display("FAIL err_start cyc=%0d got %b want %b", cyc, out_err_start, exp_err_start); end
      if (ab) begin
        checks++;
        if (out_busy !== 1'b0 || out_intr !== 1'b0)
          begin errors++; $display("FAIL abort cyc=%0d got busy=%b intr=%b want 0 0", cyc, out_busy, out_intr); end
        phase = 0;
      end else if (phase == 1) begin
        if (accepted == IN_T) begin phase = 2; idle = 0; end
        checks++;
        if (out_busy !== 1'b1 || out_intr !== 1'b0 || out_err_timeout !== 1'b0)
          begin errors++; $display("FAIL feed cyc=%0d got busy=%b intr=%b to=%b want 1 0 0", cyc,
                                   out_busy, out_intr, out_err_timeout); end
      end else if (phase == 2) begin
        idle = hs ? 0 : idle + 1;
        exp_to = (idle == TO) && (hs_cnt < OUT_T);
        checks++;
        if (out_err_timeout !== exp_to)
          begin errors++; $display("FAIL timeout cyc=%0d idle=%0d got %b want %b", cyc, idle, out_err_timeout, exp_to); end
        if (exp_to) begin
          to_gap = cyc - last_hs;
          checks++;
          if (out_intr !== 1'b1)
            begin errors++; $display("FAIL to_intr cyc=%0d got %b want 1", cyc, out_intr); end
        end else if (out_intr === 1'b1 && hs_cnt < OUT_T) begin
          checks++; errors++;
          $display("FAIL early_intr cyc=%0d got 1 want 0", cyc);
        end
        if (out_intr === 1'b1 || exp_to) begin intr_seen++; phase = 3; end
      end else begin
        checks++;
        if (out_intr !== 1'b0 || out_busy !== 1'b0)
          begin errors++; $display("FAIL after_done cyc=%0d got intr=%b busy=%b want 0 0", cyc, out_intr, out_busy); end
        phase = 0;
      end
      if (stop_drain && phase == 2) phase = 0;
    end
    if (phase != 0) begin
      checks++; errors++;
      $display("FAIL bound frame did not finish in %0d cycles got phase %0d want 0", BOUND, phase);
    end
    idle_inputs();
    $display("frame: offered=%0d accepted=%0d handshakes=%0d intr=%0d cycles=%0d",
             offer_n, accepted, hs_cnt, intr_seen, cyc);
  endtask

  task automatic test_reset();
    idle_inputs();
    in_rst = 1;
    tick(); tick();
    in_rst = 0;
    model_pix = 8'h00;
    checks++;
    if (out_busy !== 0 || out_intr !== 0 || out_data_ready !== 0 || out_pixel_data_valid !== 0)
      begin errors++; $display("FAIL reset_ctl got busy=%b intr=%b rdy=%b pv=%b want 0", out_busy, out_intr, out_data_ready, out_pixel_data_valid); end
    checks++;
    if (out_pixel_data !== 8'h00 || out_in_count !== '0 || out_out_count !== '0 ||
        out_err_start !== 0 || out_err_timeout !== 0)
      begin errors++; $display("FAIL reset_data got pd=%h in=%0d out=%0d es=%b et=%b want 0", out_pixel_data, out_in_count, out_out_count, out_err_start, out_err_timeout); end
  endtask

  task automatic test_nominal();
    int a, h, n, g;
    drive_frame(IN_T, -1, 0, 0, 0, OUT_T, -1, -1, 0, a, h, n, g);
    checks++;
    if (a != IN_T || h != OUT_T || n != 1)
      begin errors++; $display("FAIL nominal got acc=%0d hs=%0d intr=%0d want %0d %0d 1", a, h, n, IN_T, OUT_T); end
    checks++;
    if (out_busy !== 0 || out_in_count !== CW'(IN_T) || out_out_count !== CW'(OUT_T))
      begin errors++; $display("FAIL nominal_hold got busy=%b in=%0d out=%0d want 0 %0d %0d", out_busy, out_in_count, out_out_count, IN_T, OUT_T); end
  endtask

  task automatic test_backpressure();
    int a, h, n, g;
    drive_frame(IN_T, 10, 5, 0, 0, OUT_T, -1, -1, 0, a, h, n, g);
    checks++;
    if (a != IN_T || out_in_count !== CW'(IN_T) || n != 1)
      begin errors++; $display("FAIL backpressure got acc=%0d in=%0d intr=%0d want %0d %0d 1", a, out_in_count, n, IN_T, IN_T); end
  endtask

  task automatic test_overlength();
    int a, h, n, g;
    drive_frame(40, -1, 0, 0, 0, OUT_T, -1, -1, 0, a, h, n, g);
    checks++;
    if (a != IN_T || out_in_count !== CW'(IN_T))
      begin errors++; $display("FAIL overlength got acc=%0d in=%0d want %0d", a, out_in_count, IN_T); end
  endtask

  task automatic test_start_busy();
    int a, h, n, g;
    drive_frame(IN_T, -1, 0, 0, 0, OUT_T, 5, -1, 0, a, h, n, g);
    checks++;
    if (out_err_start !== 1'b1 || a != IN_T || n != 1)
      begin errors++; $display("FAIL start_busy got err=%b acc=%0d intr=%0d want 1 %0d 1", out_err_start, a, n, IN_T); end
    in_start = 1;
    tick();
    in_start = 0;
    checks++;
    if (out_err_start !== 1'b0 || out_busy !== 1'b1 || out_in_count !== '0 || out_out_count !== '0)
      begin errors++; $display("FAIL start_clear got err=%b busy=%b in=%0d out=%0d want 0 1 0 0", out_err_start, out_busy, out_in_count, out_out_count); end
    in_abort = 1;
    tick();
    in_abort = 0;
    checks++;
    if (out_busy !== 1'b0)
      begin errors++; $display("FAIL start_abort got busy=%b want 0", out_busy); end
    $display("start_busy: restart cleared error, aborted");
  endtask

  task automatic test_timeout();
    int a, h, n, g;
    drive_frame(IN_T, -1, 0, 0, 40, 10, -1, -1, 0, a, h, n, g);
    checks++;
    if (g != TO || h != 10 || n != 1)
      begin errors++; $display("FAIL timeout_gap got gap=%0d hs=%0d intr=%0d want %0d 10 1", g, h, n, TO); end
    checks++;
    if (out_err_timeout !== 1'b1 || out_out_count !== CW'(10))
      begin errors++; $display("FAIL timeout_hold got to=%b out=%0d want 1 10", out_err_timeout, out_out_count); end
  endtask

  task automatic test_abort();
    int a, h, n, g;
    drive_frame(IN_T, -1, 0, 0, 0, 4, -1, 12, 0, a, h, n, g);
    repeat (3) tick();
    checks++;
    if (a != 12 || n != 0 || out_in_count !== CW'(12) || out_busy !== 0 || out_intr !== 0)
      begin errors++; $display("FAIL abort_hold got acc=%0d intr=%0d in=%0d busy=%b want 12 0 12 0", a, n, out_in_count, out_busy); end
  endtask

  task automatic test_reset_drain();
    int a, h, n, g;
    drive_frame(IN_T, -1, 0, 0, 0, 3, -1, -1, 1, a, h, n, g);
    in_rst = 1;
    tick();
    model_pix = 8'h00;
    checks++;
    if (out_busy !== 0 || out_intr !== 0 || out_pixel_data_valid !== 0 || out_pixel_data !== 8'h00 ||
        out_in_count !== '0 || out_out_count !== '0 || out_err_start !== 0 || out_err_timeout !== 0)
      begin errors++; $display("FAIL reset_drain got busy=%b pd=%h in=%0d out=%0d want all 0", out_busy, out_pixel_data, out_in_count, out_out_count); end
    in_rst = 0;
    tick();
  endtask

  task automatic test_random();
    int a, h, n, g;
    for (int k = 0; k < 3; k++) begin
      drive_frame(IN_T, -1, 0, 1, 0, OUT_T, -1, -1, 0, a, h, n, g);
      checks++;
      if (a != IN_T || h != OUT_T || n != 1)
        begin errors++; $display("FAIL random%0d got acc=%0d hs=%0d intr=%0d want %0d %0d 1", k, a, h, n, IN_T, OUT_T); end
    end
  endtask

  initial begin
    idle_inputs();
    in_rst = 1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_overlength();
    test_start_busy();
    test_timeout();
    test_abort();
    test_reset_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
